dvp_cam_tx: RTL and testbench
=============================

# dvp_cam_tx

Camera-side DVP transmitter: generates an OV7670-style parallel video stream (vsync, href, 8-bit data, RGB444 two bytes per pixel) from an internal test pattern. It is the transmitting end of the interface that `capture` receives. It replaces the physical sensor in simulation and in on-board loopback bring-up, so the capture → CDC FIFO → BRAM → HDMI path can be exercised without a camera. All outputs are registered and change on the rising edge of `i_clk`, which is the same clock the receiver samples on.

## Interface
- H_ACTIVE, 640, active pixels per line (each pixel is 2 bytes)
- H_BLANK, 288, blanking byte-cycles per line (href low)
- V_SYNC, 3, vsync-high lines per frame
- V_BP, 17, back-porch lines after vsync
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, front-porch lines before next vsync
- i_clk  in  1  pixel/byte clock, one byte per cycle (stands in for camera pclk)
- i_rst  in  1  synchronous, active-high reset
- i_en  in  1  run request: frames stream continuously while high
- o_vsync  out  1  frame sync, active high
- o_href  out  1  line-valid, high during active bytes
- o_data  out  8  pixel byte
- o_busy  out  1  high whenever state ≠ IDLE
- o_frame_done  out  1  one-cycle pulse on the last cycle of each frame
- o_frame_cnt  out  16  completed frames, wraps 0xFFFF→0

## Operation
- LINE_BYTES = 2·H_ACTIVE + H_BLANK (default 1568). Each line is exactly LINE_BYTES cycles, in every state except IDLE.
- The FSM has five states: IDLE → VSYNC → VBP → ACTIVE → VFP, then → VSYNC or IDLE.
- Counters:
  - hcnt counts 0..LINE_BYTES-1 and runs in every non-IDLE state.
  - vcnt counts lines within the current state and clears on each state change.
- IDLE:
  - All outputs are 0 except o_frame_cnt.
  - Leaves for VSYNC when i_en=1 is sampled.
- VSYNC: o_vsync=1 for V_SYNC·LINE_BYTES cycles.
- VBP: V_BP lines, o_vsync=0, o_href=0.
- ACTIVE: V_ACTIVE lines. Within each line:
  - For hcnt < 2·H_ACTIVE: o_href=1.
    - Even hcnt carries byte0 = {4'h0, R}.
    - Odd hcnt carries byte1 = {G, B} of pixel x = hcnt>>1.
  - For the remaining H_BLANK cycles: o_href=0 and o_data=0.
- VFP: V_FP lines with all signals low.
  - On the last cycle, o_frame_done=1 and o_frame_cnt increments.
  - Next state is VSYNC if i_en=1 on that cycle, otherwise IDLE.
- Dropping i_en mid-frame has no effect until the frame ends. Frames are never truncated.
- o_data is 0 whenever o_href=0.
- Default pattern is 8 vertical colour bars, each H_ACTIVE/8 pixels wide. The bar index is x·8/H_ACTIVE. RGB444 colours in order:
  - FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
- Requirement: H_ACTIVE must be a multiple of 8 and all parameters must be ≥ 1. Enforce with an elaboration-time check.

## Timing
- Reset values:
  - State is IDLE; hcnt and vcnt are 0.
  - All outputs are 0, including o_frame_cnt.
- Reset mid-frame returns to IDLE on the next edge with outputs low. No partial frame_done is produced.
- Latency: when i_en=1 is sampled in IDLE at edge N, o_vsync=1 from edge N+1.
- The first o_href rise comes (V_SYNC+V_BP)·LINE_BYTES cycles after the o_vsync rise.
- Frame period = (V_SYNC+V_BP+V_ACTIVE+V_FP)·LINE_BYTES cycles. The default is 510·1568 cycles.
- Back-to-back frames: o_vsync rises on the cycle immediately after o_frame_done, with no idle gap.
- o_frame_done and the o_frame_cnt update occur on the same edge.

## Configuration
- `DVP_CAM_TX_RAMP_EN` selects the pattern:
  - Defined: the pattern is a moving ramp, RGB444 pixel = (x + line + o_frame_cnt) mod 4096. line is the active-line index and the sum is 12 bits. The pattern shifts by one each frame, so dropped or repeated frames are detectable downstream.
  - Undefined: the colour-bar pattern only, and the ramp logic is absent.
- Timing, handshake and all ports are identical in both builds.

## Structure
- Package `dvp_pkg`:
  - FSM state enum.
  - Default timing constants (OV7670 VGA).
  - 8-entry RGB444 bar colour table.
  - Byte-packing function (12-bit pixel → byte0/byte1).
- Sub-module `dvp_pattern_gen`: combinational/registered pixel source taking x, line, frame count and returning 12-bit RGB444. This sub-module contains the `DVP_CAM_TX_RAMP_EN` selection. The top holds the FSM and counters only.

## Test plan
Small parameters for all tests: H_ACTIVE=8, H_BLANK=4, V_SYNC=1, V_BP=1, V_ACTIVE=2, V_FP=1, giving LINE_BYTES=20 and a frame of 100 cycles.
- Reset then i_en=1 held for one cycle: o_vsync is high for cycles 1–20 exactly, then 80 cycles with o_vsync low, o_frame_done on cycle 100, state back to IDLE, o_frame_cnt=1.
- Bar build, first active line: o_data sequence is 00,0F? per byte pair = {0F,FF},{0F,F0},{00,FF},{00,F0},{0F,0F},{0F,00},{00,0F},{00,00}. o_href is high for exactly 16 cycles, then low for 4 cycles with data 00.
- i_en held high for 3 frames: o_vsync rises at cycles 1, 101 and 201; o_frame_cnt reads 3; there are no gap cycles.
- i_en dropped at cycle 50 of a frame: the frame completes, o_frame_done pulses at cycle 100, then o_busy=0 and no further o_vsync.
- i_rst asserted at cycle 45 (mid-href): all outputs are 0 on the next edge, and o_frame_cnt is unchanged only if it was 0. o_frame_done never pulses for the aborted frame.
- Ramp build: pixel (x=3, line=1) in frame 2 = 12'h006, so the bytes are 00, 06. A loopback through `capture` yields the identical 12-bit word sequence.

Source files
------------

// File: rtl/dvp_pkg.sv
// Shared types and defaults for the DVP camera-side transmitter.
// Holds the FSM encoding, OV7670 VGA timing and the colour-bar table.
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFP    = 3'd4
    } state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_BLANK  = 288;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 17;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;

    localparam logic [11:0] BAR_RGB [8] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

    // RGB444 goes out as {0,R} then {G,B}
    function automatic logic [7:0] pack_byte(input logic [11:0] pix,
                                             input logic        second);
        return second ? pix[7:0] : {4'h0, pix[11:8]};
    endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Combinational RGB444 pixel source: colour bars, or a moving ramp
// when DVP_CAM_TX_RAMP_EN is defined.
module dvp_pattern_gen
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int XW       = $clog2(DEF_H_ACTIVE)
) (
    input  logic [XW-1:0] x,
`ifdef DVP_CAM_TX_RAMP_EN
    input  logic [11:0]   line,
    input  logic [11:0]   frame,
`endif
    output logic [11:0]   pix
);

`ifdef DVP_CAM_TX_RAMP_EN
    // Shifts by one per frame so dropped/repeated frames show up downstream
    always_comb begin
        pix = 12'(x) + line + frame;
    end
`else
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] idx;

    always_comb begin
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (int'(x) >= i * BAR_W) idx = 3'(i);
        end
        pix = BAR_RGB[idx];
    end
`endif

endmodule

// File: rtl/dvp_cam_tx.sv
// DVP transmitter: OV7670-style vsync/href/data stream from a test pattern.
// Pattern selected by DVP_CAM_TX_RAMP_EN (ramp) or default colour bars.
module dvp_cam_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    output logic        o_vsync,
    output logic        o_href,
    output logic [7:0]  o_data,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic [15:0] o_frame_cnt
);

    localparam int LINE_BYTES = 2 * H_ACTIVE + H_BLANK;
    localparam int HW         = $clog2(LINE_BYTES);
    localparam int XW         = $clog2(H_ACTIVE);

    if (H_ACTIVE % 8 != 0 || H_ACTIVE < 8 || H_BLANK < 1 || V_SYNC < 1 ||
        V_BP < 1 || V_ACTIVE < 1 || V_FP < 1) begin : g_bad_params
        $error("dvp_cam_tx: H_ACTIVE must be a multiple of 8, all params >= 1");
    end

    state_t          state;
    state_t          nxt;
    logic [HW-1:0]   hcnt;
    logic [15:0]     vcnt;
    int              nlines;
    logic            last_col;
    logic            last_line;
    logic            frame_end;
    logic            href_n;
    logic [XW-1:0]   x;
    logic [11:0]     pix;

    assign x = hcnt[XW:1];

    dvp_pattern_gen #(
        .H_ACTIVE(H_ACTIVE),
        .XW      (XW)
    ) u_pattern (
        .x    (x),
`ifdef DVP_CAM_TX_RAMP_EN
        .line (vcnt[11:0]),
        .frame(o_frame_cnt[11:0]),
`endif
        .pix  (pix)
    );

    always_comb begin
        nlines = 1;
        nxt    = ST_IDLE;
        unique case (state)
            ST_VSYNC:  begin nlines = V_SYNC;   nxt = ST_VBP;    end
            ST_VBP:    begin nlines = V_BP;     nxt = ST_ACTIVE; end
            ST_ACTIVE: begin nlines = V_ACTIVE; nxt = ST_VFP;    end
            ST_VFP: begin
                nlines = V_FP;
                nxt    = i_en ? ST_VSYNC : ST_IDLE;
            end
            default: begin nlines = 1; nxt = ST_IDLE; end
        endcase
    end

    assign last_col  = (int'(hcnt) == LINE_BYTES - 1);
    assign last_line = (int'(vcnt) == nlines - 1);
    assign frame_end = (state == ST_VFP) && last_col && last_line;
    assign href_n    = (state == ST_ACTIVE) && (int'(hcnt) < 2 * H_ACTIVE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            hcnt  <= '0;
            vcnt  <= '0;
        end else if (state == ST_IDLE) begin
            hcnt <= '0;
            vcnt <= '0;
            if (i_en) state <= ST_VSYNC;
        end else if (!last_col) begin
            hcnt <= hcnt + 1'b1;
        end else begin
            hcnt <= '0;
            if (last_line) begin
                vcnt  <= '0;
                state <= nxt;
            end else begin
                vcnt <= vcnt + 16'd1;
            end
        end
    end

    // Outputs are a registered decode of the current state/counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_vsync      <= 1'b0;
            o_href       <= 1'b0;
            o_data       <= 8'h00;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_cnt  <= 16'h0000;
        end else begin
            o_vsync      <= (state == ST_VSYNC);
            o_href       <= href_n;
            o_data       <= href_n ? pack_byte(pix, hcnt[0]) : 8'h00;
            o_busy       <= (state != ST_IDLE);
            o_frame_done <= frame_end;
            if (frame_end) o_frame_cnt <= o_frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_dvp_cam_tx.sv
// Directed bench for dvp_cam_tx with small timing (20-byte lines,
// 100-cycle frames); checks sync timing, bar bytes, restart and reset.
module tb_dvp_cam_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    localparam int MAXC = 400;
    logic        r_vs [MAXC];
    logic        r_hr [MAXC];
    logic [7:0]  r_dt [MAXC];
    logic        r_fd [MAXC];
    logic        r_bz [MAXC];
    logic [15:0] r_fc [MAXC];

    dvp_cam_tx #(
        .H_ACTIVE(8), .H_BLANK(4), .V_SYNC(1),
        .V_BP(1), .V_ACTIVE(2), .V_FP(1)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .o_vsync     (vsync),
        .o_href      (href),
        .o_data      (data),
        .o_busy      (busy),
        .o_frame_done(frame_done),
        .o_frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic record(input int c);
        r_vs[c] = vsync;
        r_hr[c] = href;
        r_dt[c] = data;
        r_fd[c] = frame_done;
        r_bz[c] = busy;
        r_fc[c] = frame_cnt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Edge 0 samples en=1; en stays high through edge en_until
    task automatic run(input int n, input int en_until);
        en = 1'b1;
        step();
        record(0);
        for (int c = 1; c <= n; c++) begin
            en = (c <= en_until);
            step();
            record(c);
        end
        en = 1'b0;
    endtask

    function automatic int count_vs(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) n += int'(r_vs[c]);
        return n;
    endfunction

    function automatic int count_fd(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) n += int'(r_fd[c]);
        return n;
    endfunction

    function automatic int count_bz(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) n += int'(r_bz[c]);
        return n;
    endfunction

    function automatic int count_hr(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) n += int'(r_hr[c]);
        return n;
    endfunction

    function automatic int first_rise(input int a, input int b);
        for (int c = a; c <= b; c++) begin
            if (r_hr[c] && !r_hr[c-1]) return c;
        end
        return -1;
    endfunction

    logic [7:0] bars [16] = '{
        8'h0F, 8'hFF, 8'h0F, 8'hF0, 8'h00, 8'hFF, 8'h00, 8'hF0,
        8'h0F, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00
    };

    initial begin
        rst = 1'b1;
        en  = 1'b0;

        // Reset state
        step();
        check("rst_vsync", int'(vsync), 0);
        check("rst_href", int'(href), 0);
        check("rst_data", int'(data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_fcnt", int'(frame_cnt), 0);

        // Single-cycle enable: one full frame, then idle
        do_reset();
        run(110, 0);
        check("p_vs_c0", int'(r_vs[0]), 0);
        check("p_vs_c1", int'(r_vs[1]), 1);
        check("p_vs_c20", int'(r_vs[20]), 1);
        check("p_vs_c21", int'(r_vs[21]), 0);
        check("p_vs_cnt", count_vs(1, 110), 20);
        check("p_fd_c99", int'(r_fd[99]), 0);
        check("p_fd_c100", int'(r_fd[100]), 1);
        check("p_fd_cnt", count_fd(1, 110), 1);
        check("p_fc_c99", int'(r_fc[99]), 0);
        check("p_fc_c100", int'(r_fc[100]), 1);
        check("p_bz_c100", int'(r_bz[100]), 1);
        check("p_bz_c101", int'(r_bz[101]), 0);
        check("p_bz_cnt", count_bz(1, 110), 100);
        check("p_href_rise", first_rise(1, 110), 41);
        check("p_href_cnt", count_hr(1, 110), 32);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("bar_hr%0d", k), int'(r_hr[41+k]), 1);
            check($sformatf("bar_b%0d", k), int'(r_dt[41+k]), int'(bars[k]));
        end
        for (int k = 57; k <= 60; k++) begin
            check($sformatf("blank_hr%0d", k), int'(r_hr[k]), 0);
            check($sformatf("blank_d%0d", k), int'(r_dt[k]), 0);
        end
        check("line2_b0", int'(r_dt[61]), 8'h0F);
        check("line2_b15", int'(r_dt[76]), 8'h00);

        // Three back-to-back frames, en dropped inside the third
        do_reset();
        run(320, 250);
        check("bb_vs_c1", int'(r_vs[1]), 1);
        check("bb_vs_c100", int'(r_vs[100]), 0);
        check("bb_vs_c101", int'(r_vs[101]), 1);
        check("bb_vs_c201", int'(r_vs[201]), 1);
        check("bb_vs_cnt", count_vs(1, 320), 60);
        check("bb_fd_cnt", count_fd(1, 320), 3);
        check("bb_fd_c300", int'(r_fd[300]), 1);
        check("bb_fc_c300", int'(r_fc[300]), 3);
        check("bb_fc_c320", int'(r_fc[320]), 3);
        check("bb_bz_cnt", count_bz(1, 320), 300);

        // en dropped at cycle 50: frame still completes
        do_reset();
        run(130, 50);
        check("drop_fd_c100", int'(r_fd[100]), 1);
        check("drop_fd_cnt", count_fd(1, 130), 1);
        check("drop_bz_c101", int'(r_bz[101]), 0);
        check("drop_vs_after", count_vs(101, 130), 0);
        check("drop_fc", int'(r_fc[130]), 1);

        // Reset at cycle 45 mid-href
        do_reset();
        run(45, 200);
        check("mid_href_c45", int'(href), 1);
        rst = 1'b1;
        step();
        check("mr_vsync", int'(vsync), 0);
        check("mr_href", int'(href), 0);
        check("mr_data", int'(data), 0);
        check("mr_busy", int'(busy), 0);
        check("mr_fd", int'(frame_done), 0);
        check("mr_fcnt", int'(frame_cnt), 0);
        rst = 1'b0;
        en  = 1'b0;
        begin
            int fd_seen = 0;
            int bz_seen = 0;
            for (int c = 0; c < 120; c++) begin
                step();
                fd_seen += int'(frame_done);
                bz_seen += int'(busy);
            end
            check("mr_no_done", fd_seen, 0);
            check("mr_idle", bz_seen, 0);
        end
        check("mr_fcnt_end", int'(frame_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
